// File: rtl/uart_pkg.sv
// Shared definitions for the BCD-to-UART reporter: ASCII codes, frame length,
// top-level FSM encoding and the digit-to-ASCII mapping.
package uart_pkg;

  localparam logic [7:0] CHAR_ZERO = 8'h30;
  localparam logic [7:0] CHAR_DASH = 8'h2D;
  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_LF   = 8'h0A;

  // start + 8 data + stop
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } rpt_state_e;

  // Decimal digits map to '0'..'9'; the six non-decimal nibble codes print as '-'.
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] nib);
    if (nib <= 4'd9) begin
      return CHAR_ZERO + {4'd0, nib};
    end
    return CHAR_DASH;
  endfunction

endpackage

// File: rtl/bcd_uart_reporter_if.sv
// Request/status bundle of the BCD reporter. The master side issues send
// requests with a BCD value; the slave side reports progress and drives the line.
interface bcd_uart_reporter_if;
  logic        send_req;
  logic [23:0] bcd_data_in;
  logic        busy_out;
  logic        done_out;
  logic        rs232_tx;

  modport master (
    output send_req,
    output bcd_data_in,
    input  busy_out,
    input  done_out,
    input  rs232_tx
  );

  modport slave (
    input  send_req,
    input  bcd_data_in,
    output busy_out,
    output done_out,
    output rs232_tx
  );
endinterface

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 transmitter. A byte is accepted on any edge where tx_valid is
// high and the transmitter is idle; the start bit begins at that edge. Each bit
// is held BAUD_DIV clocks. tx_done pulses during the final clock of the stop bit
// so a caller can queue the next byte with only one idle clock between frames.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 1250
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_line
);

  localparam logic [15:0] LAST_CNT = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST_BIT = 4'(FRAME_BITS - 1);
  // Position one clock before the stop bit ends; with BAUD_DIV == 1 that is
  // the single clock of the last data bit.
  localparam logic [15:0] PRE_CNT  = (BAUD_DIV > 1) ? 16'(BAUD_DIV - 2) : 16'd0;
  localparam logic [3:0]  PRE_BIT  = (BAUD_DIV > 1) ? LAST_BIT : (LAST_BIT - 4'd1);

  logic [15:0] baud_cnt;
  logic [3:0]  bit_idx;
  logic [8:0]  shift_reg;

  // Baud counter, bit index and shifter: load on accept, shift on each bit boundary.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      tx_line   <= 1'b1;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (tx_valid) begin
          tx_busy   <= 1'b1;
          tx_line   <= 1'b0;
          shift_reg <= {1'b1, tx_data};
          baud_cnt  <= '0;
          bit_idx   <= '0;
        end
      end else begin
        tx_done <= (bit_idx == PRE_BIT) && (baud_cnt == PRE_CNT);
        if (baud_cnt == LAST_CNT) begin
          baud_cnt <= '0;
          if (bit_idx == LAST_BIT) begin
            tx_busy <= 1'b0;
            tx_line <= 1'b1;
          end else begin
            bit_idx   <= bit_idx + 4'd1;
            tx_line   <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[8:1]};
          end
        end else begin
          baud_cnt <= baud_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_uart_reporter.sv
// Captures a 6-digit BCD value and sends it as ASCII over an 8N1 UART line,
// most significant digit first, optionally followed by CR LF. A request is
// taken when idle or in the completion cycle, which allows back-to-back messages.
module bcd_uart_reporter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 12_000_000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter bit          APPEND_CRLF = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  bcd_uart_reporter_if.slave bus
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam logic [2:0]  LAST_IDX = APPEND_CRLF ? 3'd7 : 3'd5;

  rpt_state_e  state;
  logic [23:0] snapshot;
  logic [2:0]  char_idx;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_line;
  logic        busy_r;
  logic        done_r;

  // Character at position idx of the message built from bcd.
  function automatic logic [7:0] char_at(input logic [2:0] idx, input logic [23:0] bcd);
    case (idx)
      3'd0:    return digit_to_ascii(bcd[23:20]);
      3'd1:    return digit_to_ascii(bcd[19:16]);
      3'd2:    return digit_to_ascii(bcd[15:12]);
      3'd3:    return digit_to_ascii(bcd[11:8]);
      3'd4:    return digit_to_ascii(bcd[7:4]);
      3'd5:    return digit_to_ascii(bcd[3:0]);
      3'd6:    return CHAR_CR;
      default: return CHAR_LF;
    endcase
  endfunction

  // Message sequencer. The first character is presented on the accept edge
  // straight from bcd_data_in so its start bit follows one clock later.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= ST_IDLE;
      snapshot <= '0;
      char_idx <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.send_req) begin
            snapshot <= bus.bcd_data_in;
            char_idx <= '0;
            tx_data  <= char_at(3'd0, bus.bcd_data_in);
            tx_valid <= 1'b1;
            busy_r   <= 1'b1;
            state    <= ST_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          // The transmitter takes the byte on the first edge it is idle.
          if (!tx_busy) begin
            tx_valid <= 1'b0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tx_done) begin
            if (char_idx == LAST_IDX) begin
              busy_r <= 1'b0;
              done_r <= 1'b1;
              state  <= ST_DONE;
            end else begin
              char_idx <= char_idx + 3'd1;
              tx_data  <= char_at(char_idx + 3'd1, snapshot);
              tx_valid <= 1'b1;
              state    <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_line  (tx_line)
  );

  assign bus.busy_out = busy_r;
  assign bus.done_out = done_r;
  assign bus.rs232_tx = tx_line;

endmodule

// File: tb/tb_bcd_uart_reporter.sv
// Bench for bcd_uart_reporter: two instances (with and without CR LF) at short
// baud divisors, a waveform-level reference model compared every cycle, and a
// line decoder whose bytes are compared to the model and to literal messages.
module tb_bcd_uart_reporter;

  localparam int A_B = 8;    // 80 / 10
  localparam int A_L = 8;
  localparam int B_B = 7;    // 100 / 14, truncated
  localparam int B_L = 6;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  bcd_uart_reporter_if ifa ();
  bcd_uart_reporter_if ifb ();

  bcd_uart_reporter #(.CLK_FREQ(80), .BAUD_RATE(10), .APPEND_CRLF(1'b1)) dut_a (
    .clk_in   (clk_in),
    .rst_n_in (rst_n),
    .bus      (ifa)
  );

  bcd_uart_reporter #(.CLK_FREQ(100), .BAUD_RATE(14), .APPEND_CRLF(1'b0)) dut_b (
    .clk_in   (clk_in),
    .rst_n_in (rst_n),
    .bus      (ifb)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit          a_act = 1'b0, b_act = 1'b0;
  int          a_n = 0, b_n = 0;
  logic [23:0] a_snap = '0, b_snap = '0;

  logic [7:0] rxq_a [$];
  logic [7:0] rxq_b [$];
  int a_done_cnt = 0, b_done_cnt = 0;

  logic [7:0] lit_123456 [8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h0D, 8'h0A};
  logic [7:0] lit_9a0f05 [8] = '{8'h39, 8'h2D, 8'h30, 8'h2D, 8'h30, 8'h35, 8'h0D, 8'h0A};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask

  // Message character i for a captured BCD value.
  function automatic logic [7:0] char_of(input logic [23:0] d, input int i);
    logic [3:0] n;
    if (i == 6) return 8'h0D;
    if (i == 7) return 8'h0A;
    n = d[(5 - i) * 4 +: 4];
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h2D;
  endfunction

  // Line level t clocks after the accept edge: frames of 10*B clocks, one idle clock between.
  function automatic logic exp_tx(input logic [23:0] d, input int t, input int B);
    int p;
    int c;
    int w;
    int bitn;
    logic [7:0] ch;
    if (t <= 0) return 1'b1;
    p = 10 * B + 1;
    c = (t - 1) / p;
    w = (t - 1) % p;
    if (w >= 10 * B) return 1'b1;
    bitn = w / B;
    if (bitn == 0) return 1'b0;
    if (bitn == 9) return 1'b1;
    ch = char_of(d, c);
    return ch[bitn - 1];
  endfunction

  task automatic check_dut(input string nm, input logic tx, input logic busy, input logic done,
                           input bit act, input int t, input logic [23:0] d, input int B, input int L);
    logic etx, ebusy, edone;
    if (!act) begin
      etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
    end else if (t == L * (10 * B + 1)) begin
      etx = 1'b1; ebusy = 1'b0; edone = 1'b1;
    end else begin
      etx = exp_tx(d, t, B); ebusy = 1'b1; edone = 1'b0;
    end
    chk({nm, "_tx"},   32'(tx),   32'(etx));
    chk({nm, "_busy"}, 32'(busy), 32'(ebusy));
    chk({nm, "_done"}, 32'(done), 32'(edone));
  endtask

  task automatic rx_step(input logic line, input int B, inout bit busy, inout int o,
                         inout logic [7:0] by, output bit got);
    int k;
    int j;
    got = 1'b0;
    if (!busy) begin
      if (line == 1'b0) begin
        busy = 1'b1;
        o = 0;
      end
    end else begin
      o++;
      k = o - B / 2;
      if (k > 0 && (k % B) == 0) begin
        j = k / B;
        if (j <= 8) by[j - 1] = line;
        else begin
          got = 1'b1;
          busy = 1'b0;
        end
      end
    end
  endtask

  // Reference model: message bookkeeping per clock edge.
  initial forever begin
    @(posedge clk_in or negedge rst_n);
    if (!rst_n) begin
      a_act = 1'b0;
      b_act = 1'b0;
    end else begin
      cyc++;
      if (a_act && (cyc - a_n) > A_L * (10 * A_B + 1)) a_act = 1'b0;
      if (!a_act && ifa.send_req === 1'b1) begin
        a_act = 1'b1; a_n = cyc; a_snap = ifa.bcd_data_in;
      end
      if (b_act && (cyc - b_n) > B_L * (10 * B_B + 1)) b_act = 1'b0;
      if (!b_act && ifb.send_req === 1'b1) begin
        b_act = 1'b1; b_n = cyc; b_snap = ifb.bcd_data_in;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk_in);
    check_dut("A", ifa.rs232_tx, ifa.busy_out, ifa.done_out, a_act, cyc - a_n, a_snap, A_B, A_L);
    check_dut("B", ifb.rs232_tx, ifb.busy_out, ifb.done_out, b_act, cyc - b_n, b_snap, B_B, B_L);
  end

  // Line decoders and done-pulse counters.
  initial begin
    bit ra_busy = 1'b0, rb_busy = 1'b0, got;
    int ra_o = 0, rb_o = 0;
    logic [7:0] ra_by = '0, rb_by = '0;
    forever begin
      @(negedge clk_in);
      if (!rst_n) begin
        ra_busy = 1'b0;
        rb_busy = 1'b0;
      end else begin
        rx_step(ifa.rs232_tx, A_B, ra_busy, ra_o, ra_by, got);
        if (got) rxq_a.push_back(ra_by);
        rx_step(ifb.rs232_tx, B_B, rb_busy, rb_o, rb_by, got);
        if (got) rxq_b.push_back(rb_by);
      end
      if (ifa.done_out === 1'b1) a_done_cnt++;
      if (ifb.done_out === 1'b1) b_done_cnt++;
    end
  end

  task automatic send_a(input logic [23:0] d);
    ifa.bcd_data_in = d;
    ifa.send_req = 1'b1;
    @(negedge clk_in);
    ifa.send_req = 1'b0;
  endtask

  task automatic pulse_a();
    ifa.send_req = 1'b1;
    @(negedge clk_in);
    ifa.send_req = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, output int dcyc);
    int n = 0;
    while (ifa.done_out !== 1'b1 && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    chk("A_done_seen", 32'(ifa.done_out), 32'd1);
    dcyc = cyc;
  endtask

  task automatic wait_done_b(input int budget, output int dcyc);
    int n = 0;
    while (ifb.done_out !== 1'b1 && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    chk("B_done_seen", 32'(ifb.done_out), 32'd1);
    dcyc = cyc;
  endtask

  task automatic check_rx_a(input string nm);
    chk({nm, "_count"}, 32'(rxq_a.size()), 32'(A_L));
    for (int i = 0; i < A_L && i < rxq_a.size(); i++)
      chk(nm, 32'(rxq_a[i]), 32'(char_of(a_snap, i)));
    rxq_a.delete();
  endtask

  task automatic check_rx_b(input string nm);
    chk({nm, "_count"}, 32'(rxq_b.size()), 32'(B_L));
    for (int i = 0; i < B_L && i < rxq_b.size(); i++)
      chk(nm, 32'(rxq_b[i]), 32'(char_of(b_snap, i)));
    rxq_b.delete();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog cycle %0d required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dcyc;
    int base;
    ifa.send_req = 1'b0; ifa.bcd_data_in = '0;
    ifb.send_req = 1'b0; ifb.bcd_data_in = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;

    // Idle after reset.
    repeat (200) @(negedge clk_in);
    chk("idle_tx",   32'(ifa.rs232_tx), 32'd1);
    chk("idle_busy", 32'(ifa.busy_out), 32'd0);
    chk("idle_done", 32'(ifa.done_out), 32'd0);

    // 0x123456 with CR LF.
    rxq_a.delete();
    send_a(24'h123456);
    wait_done_a(2000, dcyc);
    chk("lat_crlf", 32'(dcyc - a_n), 32'd648);
    chk("lit_123456_count", 32'(rxq_a.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("lit_123456_model", 32'(char_of(a_snap, i)), 32'(lit_123456[i]));
      if (i < rxq_a.size()) chk("lit_123456_line", 32'(rxq_a[i]), 32'(lit_123456[i]));
    end
    rxq_a.delete();

    // Non-decimal digits, input changed mid-message.
    send_a(24'h9A0F05);
    repeat (150) @(negedge clk_in);
    ifa.bcd_data_in = 24'h000000;
    wait_done_a(2000, dcyc);
    chk("lit_9a0f05_count", 32'(rxq_a.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("lit_9a0f05_model", 32'(char_of(a_snap, i)), 32'(lit_9a0f05[i]));
      if (i < rxq_a.size()) chk("lit_9a0f05_line", 32'(rxq_a[i]), 32'(lit_9a0f05[i]));
    end
    rxq_a.delete();

    // Requests during the third character are ignored.
    send_a(24'($urandom()));
    base = a_done_cnt;
    repeat (190) @(negedge clk_in);
    pulse_a();
    repeat (40) @(negedge clk_in);
    pulse_a();
    wait_done_a(2000, dcyc);
    repeat (20) @(negedge clk_in);
    chk("single_done", 32'(a_done_cnt - base), 32'd1);
    check_rx_a("ignored_req_rx");

    // Reset during data bit 4 of the second character.
    send_a(24'($urandom()));
    repeat (124) @(negedge clk_in);
    @(posedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_tx",   32'(ifa.rs232_tx), 32'd1);
    chk("abort_busy", 32'(ifa.busy_out), 32'd0);
    chk("abort_done", 32'(ifa.done_out), 32'd0);
    base = a_done_cnt;
    @(posedge clk_in);
    #2 rst_n = 1'b1;
    @(negedge clk_in);
    repeat (40) @(negedge clk_in);
    chk("abort_no_done", 32'(a_done_cnt - base), 32'd0);
    rxq_a.delete();
    send_a(24'($urandom()));
    wait_done_a(2000, dcyc);
    check_rx_a("post_reset_rx");

    // Random messages, random gaps (0 = back-to-back) and stray requests.
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk_in);
      send_a(24'($urandom()));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 500)) @(negedge clk_in);
        pulse_a();
      end
      wait_done_a(2000, dcyc);
      chk("lat_rand", 32'(dcyc - a_n), 32'd648);
      check_rx_a("rand_rx");
    end

    // Continuous request without CR LF.
    ifb.bcd_data_in = 24'($urandom());
    ifb.send_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done_b(1000, dcyc);
      chk("lat_nocrlf", 32'(dcyc - b_n), 32'd426);
      check_rx_b("b2b_rx");
      if (k == 2) begin
        ifb.send_req = 1'b0;
      end else begin
        ifb.bcd_data_in = 24'($urandom());
        @(negedge clk_in);
        chk("b2b_accept_busy", 32'(ifb.busy_out), 32'd1);
        chk("b2b_accept_tx",   32'(ifb.rs232_tx), 32'd1);
        @(negedge clk_in);
        chk("b2b_start_tx",    32'(ifb.rs232_tx), 32'd0);
      end
    end
    repeat (600) @(negedge clk_in);
    chk("b_final_busy", 32'(ifb.busy_out), 32'd0);
    chk("b_final_tx",   32'(ifb.rs232_tx), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_uart_reporter.md
Name: bcd_uart_reporter

Overview:
- Transmit-side counterpart of the UART-to-segment display path.
- Captures a 6-digit BCD value, converts each digit to ASCII and serialises it on rs232_tx as 8N1 UART, most significant digit first.
- Optionally appends CR LF after the digits.
- Sits beside the display controller so the board can echo the displayed value, or any 24-bit BCD value, back to the host terminal.

Parameters:
- CLK_FREQ, 12_000_000: clk_in frequency in Hz.
- BAUD_RATE, 9600: UART bit rate.
- APPEND_CRLF, 1: 1 = send 0x0D, 0x0A after the 6 digits; 0 = digits only.
- Derived constant BAUD_DIV = CLK_FREQ/BAUD_RATE (1250 at defaults). Integer division, truncated.

Ports:
- clk_in  input  1  system clock, 12 MHz.
- rst_n_in  input  1  reset, asynchronous assert, active low.
- send_req  input  1  start request, sampled high on a rising clk_in edge.
- bcd_data_in  input  24  six BCD nibbles; [23:20] is sent first.
- busy_out  output  1  high while a message is in progress.
- done_out  output  1  one-cycle pulse when a message completes.
- rs232_tx  output  1  UART transmit line, idle high.

Behaviour:
- Reset values, applied immediately and asynchronously:
  - rs232_tx=1, busy_out=0, done_out=0.
  - FSM = IDLE; all counters, snapshot register and character index = 0.
- Reset mid-frame aborts the message. The line returns high without completing the frame. No done_out pulse.
- Accept: in IDLE, send_req=1 at edge N does the following:
  - bcd_data_in is latched into the snapshot.
  - busy_out=1 from edge N.
  - The start bit (rs232_tx=0) begins at edge N+1.
- Later changes on bcd_data_in do not affect the message in flight.
- send_req while busy_out=1 is ignored. It is not queued.
- Character sequence: index 0..5 = nibbles [23:20]..[3:0], then index 6 = 0x0D and 7 = 0x0A when APPEND_CRLF=1.
- Message length: 8 characters with CRLF, 6 without.
- Digit mapping: nibble 0..9 -> 0x30+nibble; nibble 10..15 -> 0x2D ('-').
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly BAUD_DIV clocks, so one frame = 10*BAUD_DIV clocks.
- Inter-character gap: exactly 1 clock of idle-high between one stop bit ending and the next start bit.
- Top FSM states:
  - IDLE: send_req -> LOAD.
  - LOAD: present character[idx] to the sub-module with tx_valid=1 -> WAIT.
  - WAIT: on tx_done, if idx == last -> DONE; otherwise idx+1 -> LOAD.
  - DONE: done_out=1, busy_out=0 for that cycle -> IDLE.
- The first LOAD overlaps the accept edge, so the first start bit begins at edge N+1.
- Total latency, accept edge to done_out at defaults with CRLF: 8*(10*1250) + 7 gap clocks + 1 = 100008 clocks.
- The bit counter counts 0..BAUD_DIV-1 and wraps. The bit index runs 0..9. No counter may overflow for BAUD_DIV up to 2^16-1.
- done_out and a new send_req in the same cycle: the request is accepted. This allows back-to-back messages.

Decomposition:
- Shared package (uart_pkg):
  - ASCII constants CHAR_ZERO=0x30, CHAR_DASH=0x2D, CHAR_CR=0x0D, CHAR_LF=0x0A.
  - FSM state encoding for IDLE/LOAD/WAIT/DONE.
  - Frame length constant FRAME_BITS=10.
- Sub-module uart_tx_byte:
  - Ports: clk_in, rst_n_in, tx_valid, tx_data[7:0], tx_busy, tx_done pulse, tx_line.
  - Owns the baud counter and the bit shifter.
  - Reusable for the commented-out transmit path of the UART bus.

Test Plan:
- Reset then idle 5000 clocks -> rs232_tx=1, busy_out=0, done_out=0 throughout.
- send_req with bcd_data_in=0x123456, APPEND_CRLF=1 -> line decodes 0x31,0x32,0x33,0x34,0x35,0x36,0x0D,0x0A, each bit 1250 clocks wide; done_out pulses exactly 100008 clocks after accept.
- bcd_data_in=0x9A0F05 -> line decodes 0x39,0x2D,0x30,0x2D,0x30,0x35,0x0D,0x0A. Changing bcd_data_in to 0x000000 mid-message does not alter the output.
- send_req pulsed again during the 3rd character -> ignored; only one done_out pulse; busy_out stays high until that single message ends.
- rst_n_in low for 1 cycle during data bit 4 of the 2nd character -> rs232_tx=1 within the same cycle, busy_out=0, no done_out; a new send_req afterwards transmits a full correct message.
- send_req held high continuously with APPEND_CRLF=0 -> consecutive messages of 6 characters; done_out and the next start are accepted in the same cycle; rs232_tx goes low 1 clock after done_out.
